// File: rtl/board_run_controller.sv
// Run sequencer for the cellular-automaton board: load, single-step, timed/free runs and stop.
// Define BOARD_RUN_STABLE_DETECT_EN to end runs early when the board reaches a fixed point.
module board_run_controller #(
   parameter int unsigned BOARD_WIDTH  = 32,
   parameter int unsigned BOARD_HEIGHT = 32,
   parameter int unsigned PERIOD_WIDTH = 32,
   parameter int unsigned GEN_WIDTH    = 32
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                cmd_load,
   input  logic                                cmd_step,
   input  logic                                cmd_run,
   input  logic                                cmd_stop,
   input  logic [BOARD_WIDTH*BOARD_HEIGHT-1:0] load_data,
   input  logic [GEN_WIDTH-1:0]                gen_target,
   input  logic [PERIOD_WIDTH-1:0]             period,
   input  logic [BOARD_WIDTH*BOARD_HEIGHT-1:0] board_state,
   output logic                                set_state,
   output logic                                generate_state,
   output logic [BOARD_WIDTH*BOARD_HEIGHT-1:0] new_board_state,
   output logic                                busy,
   output logic                                done,
   output logic                                stable,
   output logic [GEN_WIDTH-1:0]                gen_count
);

   localparam int unsigned Cells = BOARD_WIDTH * BOARD_HEIGHT;

`ifdef BOARD_RUN_STABLE_DETECT_EN
   // Spacing of at least 2 keeps every compare cycle free of a generate pulse.
   localparam logic [PERIOD_WIDTH-1:0] MinPeriod = PERIOD_WIDTH'(2);
`else
   localparam logic [PERIOD_WIDTH-1:0] MinPeriod = PERIOD_WIDTH'(1);
`endif

   typedef enum logic [1:0] {StIdle, StLoad, StRun, StWait} state_e;

   state_e                  state_q, state_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic [PERIOD_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
   logic [GEN_WIDTH-1:0]    target_q, target_d;
   logic [GEN_WIDTH-1:0]    run_cnt_q, run_cnt_d;
   logic [GEN_WIDTH-1:0]    gen_count_q, gen_count_d;
   logic [Cells-1:0]        new_board_q, new_board_d;
   logic                    set_state_q, generate_state_q, busy_q, done_q, done_d;
   logic                    stable_q, stable_d;
   logic                    match;

`ifdef BOARD_RUN_STABLE_DETECT_EN
   logic [Cells-1:0] snap_q;
   logic             cmp_q;

   // snap_q holds the pre-generation board; one cycle later board_state is post-generation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_q <= '0;
         cmp_q  <= 1'b0;
      end else begin
         cmp_q <= (state_q == StRun);
         if (state_q == StRun) snap_q <= board_state;
      end
   end

   assign match = cmp_q && (snap_q == board_state);
`else
   logic unused_board_state;
   assign unused_board_state = ^board_state;
   assign match = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      wait_cnt_d  = wait_cnt_q;
      target_d    = target_q;
      run_cnt_d   = run_cnt_q;
      gen_count_d = gen_count_q;
      new_board_d = new_board_q;
      stable_d    = stable_q;
      done_d      = 1'b0;

      if (match) stable_d = 1'b1;

      unique case (state_q)
         StIdle: begin
            if (!cmd_stop) begin
               if (cmd_load) begin
                  new_board_d = load_data;
                  gen_count_d = '0;
                  stable_d    = 1'b0;
                  state_d     = StLoad;
               end else if (cmd_run) begin
                  period_d  = (period < MinPeriod) ? MinPeriod : period;
                  target_d  = gen_target;
                  run_cnt_d = '0;
                  state_d   = StRun;
               end else if (cmd_step) begin
                  // A step is a run with a target of one generation.
                  target_d  = GEN_WIDTH'(1);
                  run_cnt_d = '0;
                  state_d   = StRun;
               end
            end
         end
         StLoad: begin
            state_d = StIdle;
            done_d  = 1'b1;
         end
         StRun: begin
            if (((target_q != '0) && (run_cnt_q == target_q)) || cmd_stop) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else if (period_q == PERIOD_WIDTH'(1)) begin
               state_d = StRun;
            end else begin
               state_d    = StWait;
               wait_cnt_d = PERIOD_WIDTH'(1);
            end
         end
         StWait: begin
            if (cmd_stop || match) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end else if (wait_cnt_q == period_q - PERIOD_WIDTH'(1)) begin
               state_d = StRun;
            end else begin
               wait_cnt_d = wait_cnt_q + PERIOD_WIDTH'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Entering RUN is what issues a generate pulse, so count it here.
      if (state_d == StRun) begin
         run_cnt_d   = run_cnt_d + GEN_WIDTH'(1);
         gen_count_d = gen_count_d + GEN_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= StIdle;
         period_q         <= '0;
         wait_cnt_q       <= '0;
         target_q         <= '0;
         run_cnt_q        <= '0;
         gen_count_q      <= '0;
         new_board_q      <= '0;
         set_state_q      <= 1'b0;
         generate_state_q <= 1'b0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         stable_q         <= 1'b0;
      end else begin
         state_q          <= state_d;
         period_q         <= period_d;
         wait_cnt_q       <= wait_cnt_d;
         target_q         <= target_d;
         run_cnt_q        <= run_cnt_d;
         gen_count_q      <= gen_count_d;
         new_board_q      <= new_board_d;
         set_state_q      <= (state_d == StLoad);
         generate_state_q <= (state_d == StRun);
         busy_q           <= (state_d != StIdle);
         done_q           <= done_d;
         stable_q         <= stable_d;
      end
   end

   assign set_state       = set_state_q;
   assign generate_state  = generate_state_q;
   assign new_board_state = new_board_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign stable          = stable_q;
   assign gen_count       = gen_count_q;

endmodule

// File: tb/tb_board_run_controller.sv
// Scoreboard bench for board_run_controller: stimulus queues the expected done-time response,
// a negedge monitor accumulates pulse/busy masks and checks them when done fires.
module tb_board_run_controller;

   localparam int unsigned BW    = 32;
   localparam int unsigned BH    = 32;
   localparam int unsigned PW    = 32;
   localparam int unsigned GW    = 32;
   localparam int unsigned CELLS = BW * BH;
`ifdef BOARD_RUN_STABLE_DETECT_EN
   localparam int MINP = 2;
`else
   localparam int MINP = 1;
`endif

   logic             clk, rst;
   logic             cmd_load, cmd_step, cmd_run, cmd_stop;
   logic [CELLS-1:0] load_data, board_state, new_board_state, block_pat;
   logic [GW-1:0]    gen_target, gen_count;
   logic [PW-1:0]    period;
   logic             set_state, generate_state, busy, done, stable;
   logic             still_mode;
   int               cyc = 0;
   int               checks = 0;
   int               errors = 0;

   board_run_controller #(
      .BOARD_WIDTH (BW),
      .BOARD_HEIGHT(BH),
      .PERIOD_WIDTH(PW),
      .GEN_WIDTH   (GW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_load       (cmd_load),
      .cmd_step       (cmd_step),
      .cmd_run        (cmd_run),
      .cmd_stop       (cmd_stop),
      .load_data      (load_data),
      .gen_target     (gen_target),
      .period         (period),
      .board_state    (board_state),
      .set_state      (set_state),
      .generate_state (generate_state),
      .new_board_state(new_board_state),
      .busy           (busy),
      .done           (done),
      .stable         (stable),
      .gen_count      (gen_count)
   );

   // Board model: a still life, or a board that changes every cycle.
   assign board_state = still_mode ? block_pat : CELLS'(cyc);

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      string            name;
      int               cmd_cyc;
      int               lat;
      logic [31:0]      pm;
      logic [31:0]      sm;
      logic [31:0]      bm;
      logic [GW-1:0]    gc;
      logic             st;
      logic [CELLS-1:0] nbs;
   } exp_t;

   exp_t sbq[$];

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   function automatic logic [31:0] pmask(input int n, input int eff);
      logic [31:0] m;
      m = '0;
      for (int k = 0; k < n; k++) if (1 + k * eff < 32) m[1 + k * eff] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] bmask(input int last);
      logic [31:0] m;
      m = '0;
      for (int k = 1; k <= last; k++) m[k] = 1'b1;
      return m;
   endfunction

   function automatic int effp(input int p);
      return (p < MINP) ? MINP : p;
   endfunction

   // Monitor: pulses are recorded as offsets from the command cycle of the queue head.
   logic [31:0] m_pm = '0, m_sm = '0, m_bm = '0;
   logic        m_both = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      int   off;
      if (rst || sbq.size() == 0) begin
         if (!rst && done) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
         end
         m_pm = '0; m_sm = '0; m_bm = '0; m_both = 1'b0;
      end else begin
         off = cyc - sbq[0].cmd_cyc;
         if (off >= 0 && off < 32) begin
            if (generate_state) m_pm[off] = 1'b1;
            if (set_state)      m_sm[off] = 1'b1;
            if (busy)           m_bm[off] = 1'b1;
         end
         if (set_state && generate_state) m_both = 1'b1;
         if (done) begin
            e = sbq.pop_front();
            chk({e.name, "_latency"},   64'(off),       64'(e.lat));
            chk({e.name, "_gen_mask"},  64'(m_pm),      64'(e.pm));
            chk({e.name, "_set_mask"},  64'(m_sm),      64'(e.sm));
            chk({e.name, "_busy_mask"}, 64'(m_bm),      64'(e.bm));
            chk({e.name, "_gen_count"}, 64'(gen_count), 64'(e.gc));
            chk({e.name, "_stable"},    64'(stable),    64'(e.st));
            chk({e.name, "_board_eq"},  64'(new_board_state == e.nbs), 64'(1));
            chk({e.name, "_exclusive"}, 64'(m_both),    64'(0));
            m_pm = '0; m_sm = '0; m_bm = '0; m_both = 1'b0;
         end
      end
   end

   task automatic issue(input logic l, input logic r, input logic s, input logic p, output int c);
      cmd_load = l; cmd_run = r; cmd_step = s; cmd_stop = p;
      c = cyc;
      @(posedge clk); #1;
      cmd_load = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_stop = 1'b0;
   endtask

   task automatic push(input string n, input int c, input int lat, input logic [31:0] pm,
                       input logic [31:0] sm, input logic [31:0] bm, input logic [GW-1:0] gc,
                       input logic st, input logic [CELLS-1:0] nbs);
      exp_t e;
      e.name = n; e.cmd_cyc = c; e.lat = lat; e.pm = pm; e.sm = sm; e.bm = bm;
      e.gc = gc; e.st = st; e.nbs = nbs;
      sbq.push_back(e);
   endtask

   task automatic goto_cycle(input int t);
      while (cyc < t) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_stop_at(input int t);
      goto_cycle(t);
      cmd_stop = 1'b1;
      @(posedge clk); #1;
      cmd_stop = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout_%s: %0d responses outstanding, expected 0", sbq[0].name,
                  sbq.size());
         sbq.delete();
      end
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      int c, e3, n3, e8;
      rst = 1'b1;
      cmd_load = 1'b0; cmd_step = 1'b0; cmd_run = 1'b0; cmd_stop = 1'b0;
      load_data = '0; gen_target = '0; period = '0; still_mode = 1'b0;
      block_pat = '0;
      block_pat[0] = 1'b1; block_pat[1] = 1'b1; block_pat[BW] = 1'b1; block_pat[BW+1] = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_set_state", 64'(set_state), 64'(0));
      chk("rst_generate",  64'(generate_state), 64'(0));
      chk("rst_board",     64'(|new_board_state), 64'(0));
      chk("rst_busy",      64'(busy), 64'(0));
      chk("rst_done",      64'(done), 64'(0));
      chk("rst_stable",    64'(stable), 64'(0));
      chk("rst_gen_count", 64'(gen_count), 64'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Load pattern 5.
      load_data = CELLS'(5);
      issue(1'b1, 1'b0, 1'b0, 1'b0, c);
      push("load", c, 2, 32'h0, 32'h2, 32'h2, GW'(0), 1'b0, CELLS'(5));
      drain(20);

      // Run 3 generations at period 4; mid-run input changes must be ignored.
      gen_target = GW'(3); period = PW'(4);
      issue(1'b0, 1'b1, 1'b0, 1'b0, c);
      push("run3", c, 10, pmask(3, 4), 32'h0, bmask(9), GW'(3), 1'b0, CELLS'(5));
      gen_target = GW'(1); period = PW'(1);
      drain(40);

      // Free-run with period 0, stopped at t+6.
      gen_target = GW'(0); period = PW'(0);
      e3 = effp(0);
      n3 = (6 - 1) / e3 + 1;
      issue(1'b0, 1'b1, 1'b0, 1'b0, c);
      push("freerun_stop", c, 7, pmask(n3, e3), 32'h0, bmask(6), GW'(3 + n3), 1'b0, CELLS'(5));
      pulse_stop_at(c + 6);
      drain(40);

      // Load, run and step together: only the load executes.
      load_data = CELLS'(10); gen_target = GW'(2); period = PW'(3);
      issue(1'b1, 1'b1, 1'b1, 1'b0, c);
      push("simul_load", c, 2, 32'h0, 32'h2, 32'h2, GW'(0), 1'b0, CELLS'(10));
      drain(20);

      // Step during a run's WAIT is dropped.
      issue(1'b0, 1'b1, 1'b0, 1'b0, c);
      push("run_step_ignored", c, 5, pmask(2, 3), 32'h0, bmask(4), GW'(2), 1'b0, CELLS'(10));
      goto_cycle(c + 2);
      cmd_step = 1'b1;
      @(posedge clk); #1;
      cmd_step = 1'b0;
      drain(40);

      // Single step.
      issue(1'b0, 1'b0, 1'b1, 1'b0, c);
      push("step", c, 2, 32'h2, 32'h0, 32'h2, GW'(3), 1'b0, CELLS'(10));
      drain(20);

      // Stop in IDLE is a no-op.
      issue(1'b0, 1'b0, 1'b0, 1'b1, c);
      repeat (5) @(posedge clk);
      #1;
      chk("idle_stop_busy",      64'(busy), 64'(0));
      chk("idle_stop_generate",  64'(generate_state), 64'(0));
      chk("idle_stop_gen_count", 64'(gen_count), 64'(3));

      // Stop coincident with the final pulse: pulse issues, a single done.
      gen_target = GW'(2); period = PW'(1);
      e8 = effp(1);
      issue(1'b0, 1'b1, 1'b0, 1'b0, c);
      push("stop_on_last", c, 2 + e8, pmask(2, e8), 32'h0, bmask(1 + e8), GW'(5), 1'b0,
           CELLS'(10));
      pulse_stop_at(c + 1 + e8);
      drain(40);
      repeat (4) @(posedge clk);
      #1;

`ifdef BOARD_RUN_STABLE_DETECT_EN
      // 2x2 block is a still life: the run ends after one pulse with stable set.
      still_mode = 1'b1;
      load_data = block_pat;
      issue(1'b1, 1'b0, 1'b0, 1'b0, c);
      push("still_load", c, 2, 32'h0, 32'h2, 32'h2, GW'(0), 1'b0, block_pat);
      drain(20);
      gen_target = GW'(10); period = PW'(0);
      issue(1'b0, 1'b1, 1'b0, 1'b0, c);
      push("still_run", c, 3, 32'h2, 32'h0, bmask(2), GW'(1), 1'b1, block_pat);
      drain(40);
      still_mode = 1'b0;
`endif

      // Reset in the middle of a free run at period 1.
      gen_target = GW'(0); period = PW'(1);
      issue(1'b0, 1'b1, 1'b0, 1'b0, c);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midrst_generate",  64'(generate_state), 64'(0));
      chk("midrst_busy",      64'(busy), 64'(0));
      chk("midrst_gen_count", 64'(gen_count), 64'(0));
      chk("midrst_board",     64'(|new_board_state), 64'(0));
      chk("midrst_set_done",  64'({set_state, done, stable}), 64'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("postrst_busy",     64'(busy), 64'(0));
      chk("postrst_generate", 64'(generate_state), 64'(0));
      chk("postrst_count",    64'(gen_count), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/board_run_controller.md
Name: board_run_controller

Overview:
- Sequences the cellular-automaton board register by driving its set_state, generate_state and new_board_state inputs.
- Accepts software-level commands decoded from the AXI register block: load a pattern, single-step, run N generations or free-run at a programmable rate, and stop.
- Counts generations and reports busy/done status back to the register block.
- Sits between the AXI slave register file and the board instance.

Parameters:
- BOARD_WIDTH, 32, cells per row.
- BOARD_HEIGHT, 32, rows.
- PERIOD_WIDTH, 32, width of the inter-generation period field.
- GEN_WIDTH, 32, width of the generation target and counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_load  in  1  one-cycle command strobe: load pattern.
- cmd_step  in  1  one-cycle command strobe: single generation.
- cmd_run  in  1  one-cycle command strobe: start run.
- cmd_stop  in  1  one-cycle command strobe: abort run.
- load_data  in  BOARD_WIDTH*BOARD_HEIGHT  pattern to load.
- gen_target  in  GEN_WIDTH  generations per run; 0 = free-run.
- period  in  PERIOD_WIDTH  clock cycles between generate pulses; 0 is treated as 1.
- board_state  in  BOARD_WIDTH*BOARD_HEIGHT  current board output.
- set_state  out  1  to board.
- generate_state  out  1  to board.
- new_board_state  out  BOARD_WIDTH*BOARD_HEIGHT  to board.
- busy  out  1  high while in LOAD, RUN or WAIT.
- done  out  1  one-cycle completion pulse.
- stable  out  1  sticky flag: board reached a fixed point.
- gen_count  out  GEN_WIDTH  generations issued since the last load.

Behaviour:
- Reset state: IDLE; all outputs 0, including new_board_state and gen_count. Internal period and run counters are 0.
- All outputs are registered.
- States: IDLE, LOAD, RUN, WAIT.
- Commands are honoured only in IDLE, except cmd_stop. Commands that arrive in any other state are dropped. Simultaneous commands in IDLE resolve with priority stop > load > run > step; a stop in IDLE is a no-op.
- cmd_load at cycle t:
  - new_board_state <= load_data; state -> LOAD.
  - At t+1: set_state=1 for exactly one cycle; gen_count=0; stable=0.
  - At t+2: done=1, state IDLE.
- cmd_step at t: generate_state=1 at t+1 only; gen_count increments at t+1; done=1 at t+2.
- cmd_run at t:
  - Latch eff_period = max(period,1) and gen_target; clear the run counter; state -> RUN.
  - RUN: generate_state=1 for one cycle and gen_count+1. If the run is complete, go to IDLE; otherwise go to WAIT.
  - WAIT: counts eff_period-1 cycles, then returns to RUN. Pulses are therefore spaced exactly eff_period cycles apart. With eff_period=1, WAIT is bypassed and generate_state stays high on consecutive cycles.
  - Completion: run counter == latched gen_target, only when target != 0.
  - done=1 the cycle after the final pulse; busy falls in that same cycle.
  - Changes to period or gen_target mid-run are ignored.
- cmd_stop in RUN or WAIT: no generate pulse is issued in the following cycle; next state IDLE; done=1 next cycle; gen_count holds.
- cmd_stop coincident with the final RUN pulse: the pulse still issues and only one done pulse is produced.
- gen_count wraps modulo 2^GEN_WIDTH; the run counter is independent of it.
- set_state and generate_state are never high in the same cycle.
- Reset asserted mid-run: all outputs return to 0 immediately (asynchronous); no further pulses.

Optional Feature:
- Macro: BOARD_RUN_STABLE_DETECT_EN.
- Defined:
  - In the cycle of each generate pulse, snapshot board_state (the pre-generation state).
  - In the next cycle, compare the snapshot with board_state (the post-generation state).
  - If equal: set stable=1 (sticky until the next load or reset), end the run with done=1, and return to IDLE.
  - eff_period becomes max(period,2), so no pulse is issued during a compare cycle.
  - A single step also sets stable on a match.
- Undefined: stable is tied to 0, no snapshot register is built, and eff_period = max(period,1).

Test Plan:
- Reset mid-run with period=1 -> all outputs 0 immediately; after release, IDLE with busy=0.
- cmd_load with load_data=0x...0005 -> set_state pulses 1 cycle at t+1; new_board_state=0x...0005; gen_count=0; done at t+2.
- cmd_run with gen_target=3, period=4 -> generate_state high at t+1, t+5, t+9 only; gen_count=3; done at t+10; busy high t+1..t+9.
- cmd_run with gen_target=0, period=0, then cmd_stop at t+6 -> pulses t+1..t+6, none at t+7, done at t+7, gen_count=6.
- cmd_load, cmd_run and cmd_step asserted together in IDLE -> load only executes; cmd_step during RUN is ignored (pulse spacing unchanged).
- With BOARD_RUN_STABLE_DETECT_EN: load a 2x2 block (still life), run with gen_target=10 -> exactly one pulse, stable=1, done, gen_count=1.
